// File: rtl/ex_pkg.sv
// Shared definitions for the execute / data-memory datapath.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: ALU op encodings, forwarding-select encodings, default widths
// and the immediate sign-extension helper.
package ex_pkg;

  localparam int EX_DATA_W     = 32;
  localparam int EX_REG_ADDR_W = 5;
  localparam int EX_IMM_W      = 16;

  // ALU function field (low nibble of the decoded op). Codes 8-15 fall back to ADD.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  // Operand forwarding selects. 11 is a second encoding for register-file data.
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EXDM = 2'b01,
    FWD_WB   = 2'b10,
    FWD_RF2  = 2'b11
  } fwd_sel_e;

  function automatic logic [EX_DATA_W-1:0] sext(input logic [EX_IMM_W-1:0] imm);
    return {{(EX_DATA_W-EX_IMM_W){imm[EX_IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/ex_dm_datapath_alu_core.sv
// Combinational ALU: op + A + B -> result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
//
// Ports:
//   i_op     ALU function code (alu_op_e encoding, unknown codes behave as ADD)
//   i_a/i_b  operands
//   o_result wrapped result; SLT yields 0/1, shifts use i_b[4:0]
module alu_core
  import ex_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  alu_op_e    w_op;
  logic [4:0] w_shamt;
  logic       w_lt;

  assign w_op    = alu_op_e'(i_op);
  assign w_shamt = i_b[4:0];
  assign w_lt    = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result = i_a + i_b;
    case (w_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_lt};
      ALU_SLL: o_result = i_a << w_shamt;
      ALU_SRL: o_result = i_a >> w_shamt;
      default: o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/ex_dm_datapath.sv
// Execute + data-memory datapath: forwarding muxes, ALU, EX/DM and DM/WB pipeline registers.
// Latency: EX operands -> dm_* outputs 1 cycle, -> wb_* outputs 2 cycles; 1 issue per cycle.
// Backpressure: none; never stalls, bubbles arrive as valid_ex=0 from the dependency checker.
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   valid_ex, a_rf, b_rf, imm,       EX-stage instruction: operands, immediate, decoded op,
//   op_dec, rw_ex, mux_sel_A/B,      destination, forwarding selects, immediate select,
//   imm_sel, mem_en_ex, mem_rw_ex    memory enable / direction
//   mem_mux_sel_dm, dm_rdata         DM-stage write-back select and memory read data
//   dm_addr, dm_wdata, dm_en, dm_rw  data-memory request (straight from EX/DM)
//   wb_data, wb_addr, wb_en          register-file write-back (DM/WB register)
module ex_dm_datapath
  import ex_pkg::*;
#(
  parameter int DATA_W     = EX_DATA_W,
  parameter int REG_ADDR_W = EX_REG_ADDR_W,
  parameter int IMM_W      = EX_IMM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_ex,
  input  logic [DATA_W-1:0]     a_rf,
  input  logic [DATA_W-1:0]     b_rf,
  input  logic [IMM_W-1:0]      imm,
  input  logic [5:0]            op_dec,
  input  logic [REG_ADDR_W-1:0] rw_ex,
  input  logic [1:0]            mux_sel_A,
  input  logic [1:0]            mux_sel_B,
  input  logic                  imm_sel,
  input  logic                  mem_en_ex,
  input  logic                  mem_rw_ex,
  input  logic                  mem_mux_sel_dm,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic [DATA_W-1:0]     dm_addr,
  output logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_en,
  output logic                  dm_rw,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  wb_en
);

  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_unused_op_hi;

  // EX/DM pipeline register
  logic [DATA_W-1:0]     r_exdm_alu;
  logic [DATA_W-1:0]     r_exdm_wdata;
  logic [REG_ADDR_W-1:0] r_exdm_rd;
  logic                  r_exdm_vld;
  logic                  r_exdm_mem_en;
  logic                  r_exdm_mem_rw;

  // DM/WB pipeline register
  logic [DATA_W-1:0]     r_wb_data;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic                  r_wb_en;

  // Only the low nibble of the decoded op selects the ALU function.
  assign w_unused_op_hi = ^op_dec[5:4];

  // Each operand muxes independently; EX/DM and WB sources may be mixed freely.
  always_comb begin
    w_fwd_a = a_rf;
    case (fwd_sel_e'(mux_sel_A))
      FWD_EXDM: w_fwd_a = r_exdm_alu;
      FWD_WB:   w_fwd_a = r_wb_data;
      default:  w_fwd_a = a_rf;
    endcase
  end

  always_comb begin
    w_fwd_b = b_rf;
    case (fwd_sel_e'(mux_sel_B))
      FWD_EXDM: w_fwd_b = r_exdm_alu;
      FWD_WB:   w_fwd_b = r_wb_data;
      default:  w_fwd_b = b_rf;
    endcase
  end

  // Store data always takes the forwarded B, even when the ALU uses the immediate.
  assign w_alu_b = imm_sel ? sext(imm) : w_fwd_b;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (op_dec[3:0]),
    .i_a      (w_fwd_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_res)
  );

  // Bubbles clear the controls but hold the data fields, so a later EX/DM
  // forward after a bubble still sees the last real result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exdm_alu    <= '0;
      r_exdm_wdata  <= '0;
      r_exdm_rd     <= '0;
      r_exdm_vld    <= 1'b0;
      r_exdm_mem_en <= 1'b0;
      r_exdm_mem_rw <= 1'b0;
    end else begin
      r_exdm_vld    <= valid_ex;
      r_exdm_mem_en <= mem_en_ex & valid_ex;
      r_exdm_mem_rw <= mem_rw_ex & valid_ex;
      if (valid_ex) begin
        r_exdm_alu   <= w_alu_res;
        r_exdm_wdata <= w_fwd_b;
        r_exdm_rd    <= rw_ex;
      end
    end
  end

  assign dm_addr  = r_exdm_alu;
  assign dm_wdata = r_exdm_wdata;
  assign dm_en    = r_exdm_mem_en;
  assign dm_rw    = r_exdm_mem_rw;

  // Stores and writes to register 0 never reach the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_data <= '0;
      r_wb_addr <= '0;
      r_wb_en   <= 1'b0;
    end else begin
      r_wb_data <= mem_mux_sel_dm ? dm_rdata : r_exdm_alu;
      r_wb_addr <= r_exdm_rd;
      r_wb_en   <= r_exdm_vld & ~(r_exdm_mem_en & r_exdm_mem_rw) & (r_exdm_rd != '0);
    end
  end

  assign wb_data = r_wb_data;
  assign wb_addr = r_wb_addr;
  assign wb_en   = r_wb_en;

endmodule
